// File: rtl/prefetch_pkg.sv
// ---------------------------------------------------------------------------
// prefetch_pkg
//   Shared types and constants for the instruction-bus prefetcher.
//   - pf_state_t : bus-side FSM states (idle, request outstanding, one-cycle gap)
//   - WORD_BYTES : size of one instruction word in bytes
// ---------------------------------------------------------------------------
package prefetch_pkg;

  typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_GAP} pf_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
//   Synchronous word FIFO holding prefetched instruction words.
//   Parameters:
//     DEPTH      number of 32-bit entries, power of two (2..16)
//   Ports:
//     clock      rising-edge clock
//     reset_n    asynchronous active-low reset (empties the FIFO)
//     clear      synchronous flush; wins over push and pop in the same cycle
//     push       write push_data at the tail (ignored when full)
//     push_data  word to write
//     pop        drop the head entry (ignored when empty)
//     head_data  word at the head, valid whenever empty is low
//     full       all DEPTH entries occupied
//     empty      no entries occupied
//     count      number of occupied entries (0..DEPTH)
// ---------------------------------------------------------------------------
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [8*WORD_BYTES-1:0]  push_data,
  input  logic                     pop,
  output logic [8*WORD_BYTES-1:0]  head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [8*WORD_BYTES-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ibus_prefetch.sv
// ---------------------------------------------------------------------------
// ibus_prefetch
//   Sequential instruction prefetcher between the CPU instruction bus and
//   bus arbiter port A. CPU fetches that match the FIFO head are served in one
//   cycle; any other fetch (or i_flush) discards buffered words and restarts
//   fetching at the new address. While idle it fetches ahead, never beyond
//   the end of the device region of the last demand address.
//   Parameters:
//     DEPTH          FIFO entries (power of two, 2..16)
//     REGION_MSB     top bit of the device-region field address[REGION_MSB:28]
//   Ports:
//     i_clock        rising-edge clock
//     i_reset_n      asynchronous active-low reset
//     i_flush        one-cycle pulse, invalidate buffered words
//     i_request      CPU fetch request, held until o_ready
//     o_ready        one-cycle pulse, o_rdata valid
//     i_address      CPU fetch address ([1:0] ignored)
//     o_rdata        instruction word
//     o_bus_request  bus request, held until i_bus_ready
//     i_bus_ready    bus completion pulse
//     o_bus_address  word-aligned bus address, stable while requesting
//     i_bus_rdata    bus read data, valid with i_bus_ready
//     o_hit_count    FIFO hits (saturating)
//     o_miss_count   demand misses (saturating)
//   Build option:
//     PREFETCH_STATS_EN  when defined, the hit/miss counters exist; otherwise
//                        both count ports are tied to zero.
// ---------------------------------------------------------------------------
module ibus_prefetch
  import prefetch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REGION_MSB = 31
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_request,
  output logic        o_ready,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  pf_state_t           state;
  logic [31:0]         fetch_addr;
  logic [31:0]         head_addr;
  logic [REGION_MSB:28] region_base;
  logic                cur_demand;
  logic                discard;
  logic                demand_pending;
  logic                demand_wait;
  logic                pf_enable;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [31:0]         fifo_head;

  logic                req_live;
  logic                hit;
  logic                miss;
  logic                bus_done;
  logic                push;
  logic                forward;
  logic                flush_fifo;
  logic                in_flight_pf;
  logic [CW:0]         occupancy;
  logic                room;
  logic                prefetch_ok;
  logic [31:0]         req_word;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, i_address[1:0]};
  assign req_word         = {i_address[31:2], 2'b00};

  // A held request is ignored in the o_ready cycle and while its own demand
  // access is outstanding; a flush re-opens it so it is replayed as a miss.
  assign req_live   = i_request && !o_ready && (!demand_wait || i_flush);
  assign hit        = req_live && !i_flush && !fifo_empty &&
                      (i_address[31:2] == head_addr[31:2]);
  assign miss       = req_live && !hit;
  assign flush_fifo = miss || i_flush;

  assign bus_done   = (state == PF_REQ) && i_bus_ready;
  assign push       = bus_done && !cur_demand && !discard && !fifo_full;
  assign forward    = bus_done && cur_demand && !discard && !i_flush && !miss;

  // Occupancy reserves a slot for the prefetch on the bus so a push never
  // lands on a full FIFO.
  assign in_flight_pf = (state == PF_REQ) && !cur_demand && !discard;
  assign occupancy    = {1'b0, fifo_count} + (CW+1)'(in_flight_pf);
  assign room         = occupancy < DEPTH_OCC;

  // The next word is fetched only while it lies in the region of the last
  // demand address; after the last word of a region the address steps into a
  // new region field (or wraps to zero) and prefetching stops.
  assign prefetch_ok = pf_enable && !discard &&
                       (fetch_addr[REGION_MSB:28] == region_base);

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (i_clock),
    .reset_n   (i_reset_n),
    .clear     (flush_fifo),
    .push      (push),
    .push_data (i_bus_rdata),
    .pop       (hit),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Bus FSM plus CPU-side bookkeeping. Later statements override earlier ones:
  // a miss redirects fetch_addr even when an access completes in that cycle.
  // An access already on the bus is never aborted; it is marked for discard.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= PF_IDLE;
      o_bus_request  <= 1'b0;
      o_bus_address  <= '0;
      o_ready        <= 1'b0;
      o_rdata        <= '0;
      fetch_addr     <= '0;
      head_addr      <= '0;
      region_base    <= '0;
      cur_demand     <= 1'b0;
      discard        <= 1'b0;
      demand_pending <= 1'b0;
      demand_wait    <= 1'b0;
      pf_enable      <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      case (state)
        PF_IDLE: begin
          if (!flush_fifo) begin
            if (demand_pending) begin
              state          <= PF_REQ;
              o_bus_request  <= 1'b1;
              o_bus_address  <= fetch_addr;
              cur_demand     <= 1'b1;
              demand_pending <= 1'b0;
            end else if (prefetch_ok && room) begin
              state         <= PF_REQ;
              o_bus_request <= 1'b1;
              o_bus_address <= fetch_addr;
              cur_demand    <= 1'b0;
            end
          end
        end
        PF_REQ: begin
          if (i_bus_ready) begin
            state         <= PF_GAP;
            o_bus_request <= 1'b0;
            discard       <= 1'b0;
            if (!discard) fetch_addr <= fetch_addr + 32'(WORD_BYTES);
          end
        end
        PF_GAP: begin
          state <= PF_IDLE;
        end
        default: begin
          state         <= PF_IDLE;
          o_bus_request <= 1'b0;
        end
      endcase

      if (forward) begin
        o_ready     <= 1'b1;
        o_rdata     <= i_bus_rdata;
        demand_wait <= 1'b0;
      end

      if (hit) begin
        o_ready   <= 1'b1;
        o_rdata   <= fifo_head;
        head_addr <= head_addr + 32'(WORD_BYTES);
      end

      if (i_flush) begin
        pf_enable      <= 1'b0;
        demand_pending <= 1'b0;
        demand_wait    <= 1'b0;
        if (state == PF_REQ && !i_bus_ready) discard <= 1'b1;
      end

      if (miss) begin
        fetch_addr     <= req_word;
        head_addr      <= req_word + 32'(WORD_BYTES);
        region_base    <= i_address[REGION_MSB:28];
        demand_pending <= 1'b1;
        demand_wait    <= 1'b1;
        pf_enable      <= 1'b1;
        if (state == PF_REQ && !i_bus_ready) discard <= 1'b1;
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end

  assign o_hit_count  = hit_count;
  assign o_miss_count = miss_count;
`else
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_ibus_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ibus_prefetch
//   Self-checking bench for ibus_prefetch. A bus responder with programmable
//   latency returns bus_word(address) and logs every completed access. Each
//   CPU fetch pushes its expected word to a scoreboard queue that is popped
//   whenever o_ready pulses.
// ---------------------------------------------------------------------------
module tb_ibus_prefetch;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_request = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_bus_ready = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic [31:0] o_hit_count;
  logic [31:0] o_miss_count;

  int vectors = 0;
  int miscompares = 0;
  int bus_latency = 2;
  logic [31:0] exp_q[$];
  logic [31:0] bus_log[$];

`ifdef PREFETCH_STATS_EN
  localparam logic [31:0] EXP_HITS   = 32'd2;
  localparam logic [31:0] EXP_MISSES = 32'd1;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  ibus_prefetch dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_flush       (i_flush),
    .i_request     (i_request),
    .o_ready       (o_ready),
    .i_address     (i_address),
    .o_rdata       (o_rdata),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .o_hit_count   (o_hit_count),
    .o_miss_count  (o_miss_count)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] bus_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic bit same_log(input logic [31:0] want[$]);
    if (bus_log.size() != want.size()) return 1'b0;
    foreach (want[i]) if (bus_log[i] !== want[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input logic [31:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  // Bus responder: i_bus_ready pulses in the bus_latency-th request cycle.
  initial begin : bus_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge i_clock);
      if (!i_reset_n) begin
        cnt = 0;
        i_bus_ready = 1'b0;
      end else if (i_bus_ready) begin
        i_bus_ready = 1'b0;
        cnt = 0;
      end else if (o_bus_request) begin
        cnt++;
        if (cnt >= bus_latency) begin
          i_bus_ready = 1'b1;
          i_bus_rdata = bus_word(o_bus_address);
          bus_log.push_back(o_bus_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every o_ready pulse must deliver the oldest expected word.
  always @(negedge i_clock) begin
    if (i_reset_n && o_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL rdata: unexpected o_ready with o_rdata=%h, want no pulse", o_rdata);
      end else begin
        logic [31:0] exp;
        exp = exp_q.pop_front();
        if (o_rdata !== exp) begin
          miscompares++;
          $display("[TB] FAIL rdata: got %h, want %h", o_rdata, exp);
        end
      end
    end
  end

  // One CPU fetch; lat = cycles from request to o_ready (0 on timeout).
  task automatic cpu_fetch(input logic [31:0] addr, input logic flush, output int lat);
    @(negedge i_clock);
    i_request = 1'b1;
    i_address = addr;
    i_flush   = flush;
    exp_q.push_back(bus_word(addr));
    lat = 0;
    for (int c = 0; c < 60 && lat == 0; c++) begin
      @(negedge i_clock);
      i_flush = 1'b0;
      if (o_ready) lat = c + 1;
    end
    i_request = 1'b0;
    if (lat == 0) begin
      vectors++;
      miscompares++;
      void'(exp_q.pop_back());
      $display("[TB] FAIL fetch_timeout: no o_ready for %h within 60 cycles", addr);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    vectors++;
    if ({o_ready, o_bus_request} !== 2'b00 || o_rdata !== '0 || o_bus_address !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: ready=%b req=%b rdata=%h addr=%h, want all 0",
               o_ready, o_bus_request, o_rdata, o_bus_address);
    end
    vectors++;
    if (o_hit_count !== '0 || o_miss_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counts: hit=%0d miss=%0d, want 0 0", o_hit_count, o_miss_count);
    end
    i_reset_n = 1'b1;
    wait_cycles(8);
    vectors++;
    if (bus_log.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: %0d bus accesses, want 0", bus_log.size());
    end
  endtask

  task automatic test_miss_fill();
    int lat;
    logic [31:0] want[$];
    bus_log.delete();
    cpu_fetch(32'h100, 1'b0, lat);
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("[TB] FAIL miss_latency: got %0d cycles, want 4", lat);
    end
    want = '{32'h100};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL demand_access: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
    wait_cycles(40);
    want = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL prefetch_fill: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
  endtask

  task automatic test_hits();
    int lat;
    logic [31:0] want[$];
    bus_log.delete();
    cpu_fetch(32'h104, 1'b0, lat);
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("[TB] FAIL hit_latency_104: got %0d cycles, want 1", lat);
    end
    cpu_fetch(32'h108, 1'b0, lat);
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("[TB] FAIL hit_latency_108: got %0d cycles, want 1", lat);
    end
    wait_cycles(20);
    want = '{32'h114, 32'h118};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL refill: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
    vectors++;
    if (o_hit_count !== EXP_HITS || o_miss_count !== EXP_MISSES) begin
      miscompares++;
      $display("[TB] FAIL stats: hit=%0d miss=%0d, want %0d %0d",
               o_hit_count, o_miss_count, EXP_HITS, EXP_MISSES);
    end
  endtask

  // Redirect while the refill of 0x11C is on the bus: its data must vanish.
  task automatic test_redirect();
    int lat;
    logic [31:0] want[$];
    bus_log.delete();
    bus_latency = 6;
    cpu_fetch(32'h10C, 1'b0, lat);
    for (int c = 0; c < 10 && !o_bus_request; c++) @(negedge i_clock);
    vectors++;
    if (o_bus_request !== 1'b1 || o_bus_address !== 32'h11C) begin
      miscompares++;
      $display("[TB] FAIL refill_req: req=%b addr=%h, want 1 0000011c", o_bus_request, o_bus_address);
    end
    cpu_fetch(32'h200, 1'b0, lat);
    want = '{32'h11C, 32'h200};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL redirect: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
    bus_latency = 2;
    wait_cycles(40);
    cpu_fetch(32'h204, 1'b0, lat);
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("[TB] FAIL hit_after_redirect: got %0d cycles, want 1", lat);
    end
  endtask

  task automatic test_region();
    int lat;
    logic [31:0] want[$];
    wait_cycles(20);
    bus_log.delete();
    cpu_fetch(32'h0FFF_FFF8, 1'b0, lat);
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("[TB] FAIL region_miss_latency: got %0d cycles, want 4", lat);
    end
    wait_cycles(30);
    want = '{32'h0FFF_FFF8, 32'h0FFF_FFFC};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL region_stop: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
    cpu_fetch(32'h1000_0000, 1'b0, lat);
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("[TB] FAIL region_cross_miss: got %0d cycles, want 4", lat);
    end
    want = '{32'h0FFF_FFF8, 32'h0FFF_FFFC, 32'h1000_0000};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL region_cross_access: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
  endtask

  task automatic test_flush_hit();
    int lat;
    logic [31:0] want[$];
    wait_cycles(30);
    bus_log.delete();
    cpu_fetch(32'h1000_0004, 1'b1, lat);
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("[TB] FAIL flush_hit_latency: got %0d cycles, want 4", lat);
    end
    want = '{32'h1000_0004};
    vectors++;
    if (!same_log(want)) begin
      miscompares++;
      $display("[TB] FAIL flush_refetch: bus log %s, want %s", fmt(bus_log), fmt(want));
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    wait_cycles(30);
    bus_latency = 8;
    @(negedge i_clock);
    i_request = 1'b1;
    i_address = 32'h300;
    for (int c = 0; c < 10 && !o_bus_request; c++) @(negedge i_clock);
    #2;
    i_reset_n = 1'b0;
    #1;
    vectors++;
    if (o_bus_request !== 1'b0 || o_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: req=%b ready=%b, want 0 0", o_bus_request, o_ready);
    end
    i_request = 1'b0;
    @(negedge i_clock);
    i_reset_n = 1'b1;
    bus_latency = 2;
    bus_log.delete();
    wait_cycles(10);
    vectors++;
    if (bus_log.size() != 0 || o_bus_request !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: %0d accesses req=%b, want 0 0", bus_log.size(), o_bus_request);
    end
    cpu_fetch(32'h300, 1'b0, lat);
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("[TB] FAIL post_reset_fetch: got %0d cycles, want 4", lat);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run still active at 500000, want finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_miss_fill();
    test_hits();
    test_redirect();
    test_region();
    test_flush_hit();
    test_reset_mid();
    wait_cycles(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d words never delivered, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
